// File: rtl/send_pkg.sv
// Shared types and default widths for the LED frame send sequencer.
package send_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } send_state_t;

    localparam int ADDR_W_DEF = 8;
    localparam int CHAN_W_DEF = 2;
    localparam int GAP_W_DEF  = 16;
    localparam int REP_W_DEF  = 8;

endpackage

// File: rtl/send_gap_timer.sv
// Loadable down-counter timing the inter-frame latch gap; holds at zero.
module send_gap_timer
    import send_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [GAP_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/send_seq.sv
// Frame send sequencer: walks (addr, chan) pairs over a pixel frame buffer.
// Optional SEND_SEQ_REVERSE_EN adds a `reverse` input for descending addresses.
module send_seq
    import send_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CHAN_W = CHAN_W_DEF,
    parameter int GAP_W  = GAP_W_DEF,
    parameter int REP_W  = REP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] length,
    input  logic [CHAN_W-1:0] chans_m1,
    input  logic [REP_W-1:0]  repeat_cnt,
    input  logic [GAP_W-1:0]  gap,
    input  logic              trigger,
    input  logic              abort,
    input  logic              next,
`ifdef SEND_SEQ_REVERSE_EN
    input  logic              reverse,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic [CHAN_W-1:0] chan,
    output logic              valid,
    output logic              last,
    output logic              frame_done,
    output logic              done
);

    send_state_t       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_offset, w_offset_nxt;
    logic [CHAN_W-1:0] r_chan, w_chan_nxt;
    logic [REP_W-1:0]  r_rep, w_rep_nxt;
    logic              r_frame_done, w_frame_done_nxt;

    // Shadow copies of the frame setup, so inputs may change after trigger.
    logic [ADDR_W-1:0] r_base, r_len;
    logic [CHAN_W-1:0] r_chans_m1;
    logic [GAP_W-1:0]  r_gap;

    logic              w_latch;
    logic              w_gap_load, w_gap_en, w_gap_zero;
    logic [ADDR_W-1:0] w_start_in, w_start_sh, w_step;

`ifdef SEND_SEQ_REVERSE_EN
    logic r_rev;

    assign w_start_in = reverse ? base + length : base;
    assign w_start_sh = r_rev ? r_base + r_len : r_base;
    assign w_step     = r_rev ? r_addr - 1'b1 : r_addr + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       r_rev <= 1'b0;
        else if (w_latch) r_rev <= reverse;
    end
`else
    assign w_start_in = base;
    assign w_start_sh = r_base;
    assign w_step     = r_addr + 1'b1;
`endif

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_offset_nxt     = r_offset;
        w_chan_nxt       = r_chan;
        w_rep_nxt        = r_rep;
        w_frame_done_nxt = 1'b0;
        w_latch          = 1'b0;
        w_gap_load       = 1'b0;

        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (trigger) begin
                        w_latch      = 1'b1;
                        w_state_nxt  = SEND;
                        w_addr_nxt   = w_start_in;
                        w_offset_nxt = '0;
                        w_chan_nxt   = '0;
                        w_rep_nxt    = repeat_cnt;
                    end
                end
                SEND: begin
                    if (next) begin
                        if (r_chan < r_chans_m1) begin
                            w_chan_nxt = r_chan + 1'b1;
                        end else begin
                            w_chan_nxt = '0;
                            if (r_offset == r_len) begin
                                w_frame_done_nxt = 1'b1;
                                w_gap_load       = 1'b1;
                                w_state_nxt      = GAP;
                            end else begin
                                w_offset_nxt = r_offset + 1'b1;
                                w_addr_nxt   = w_step;
                            end
                        end
                    end
                end
                GAP: begin
                    if (w_gap_zero) begin
                        if (r_rep == '0) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_rep_nxt    = r_rep - 1'b1;
                            w_addr_nxt   = w_start_sh;
                            w_offset_nxt = '0;
                            w_chan_nxt   = '0;
                            w_state_nxt  = SEND;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_offset     <= '0;
            r_chan       <= '0;
            r_rep        <= '0;
            r_frame_done <= 1'b0;
            r_base       <= '0;
            r_len        <= '0;
            r_chans_m1   <= '0;
            r_gap        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_offset     <= w_offset_nxt;
            r_chan       <= w_chan_nxt;
            r_rep        <= w_rep_nxt;
            r_frame_done <= w_frame_done_nxt;
            if (w_latch) begin
                r_base     <= base;
                r_len      <= length;
                r_chans_m1 <= chans_m1;
                r_gap      <= gap;
            end
        end
    end

    // Loaded with gap on frame end, so GAP lasts gap+1 cycles.
    assign w_gap_en = (r_state == GAP);

    send_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_gap_load),
        .load_val (r_gap),
        .en       (w_gap_en),
        .zero     (w_gap_zero)
    );

    assign addr       = r_addr;
    assign chan       = r_chan;
    assign valid      = (r_state == SEND);
    assign done       = (r_state == IDLE);
    assign frame_done = r_frame_done;
    assign last       = valid && (r_chan == r_chans_m1) && (r_offset == r_len);

endmodule

// File: tb/tb_send_seq.sv
// Self-checking bench for send_seq: expected element stream plus gap timing.
module tb_send_seq;

    logic        clk;
    logic        reset;
    logic [7:0]  base, length, repeat_cnt;
    logic [1:0]  chans_m1;
    logic [15:0] gap;
    logic        trigger, abort, nxt, reverse;
    logic [7:0]  addr;
    logic [1:0]  chan;
    logic        valid, last, frame_done, done;

    send_seq dut (
        .clk        (clk),
        .reset      (reset),
        .base       (base),
        .length     (length),
        .chans_m1   (chans_m1),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .trigger    (trigger),
        .abort      (abort),
        .next       (nxt),
`ifdef SEND_SEQ_REVERSE_EN
        .reverse    (reverse),
`endif
        .addr       (addr),
        .chan       (chan),
        .valid      (valid),
        .last       (last),
        .frame_done (frame_done),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame job expands into the full list of elements it must emit.
    typedef struct {
        logic [7:0] addr;
        logic [1:0] chan;
        bit         last;
    } elem_t;

    elem_t      exp_q[$];
    int         gap_left = 0;
    bit         fd_due   = 0;
    bit         pend     = 0;
    int         fd_seen  = 0;
    logic [7:0] m_base, m_len, m_rep;
    logic [1:0] m_cm1;
    int         m_gap;
    bit         m_rev;

    function automatic void build_job();
        elem_t e;
        for (int f = 0; f <= int'(m_rep); f++)
            for (int p = 0; p <= int'(m_len); p++)
                for (int c = 0; c <= int'(m_cm1); c++) begin
                    e.addr = m_rev ? 8'(int'(m_base) + int'(m_len) - p) : 8'(int'(m_base) + p);
                    e.chan = 2'(c);
                    e.last = (p == int'(m_len)) && (c == int'(m_cm1));
                    exp_q.push_back(e);
                end
    endfunction

    always @(negedge clk) begin
        elem_t e;
        if (frame_done === 1'b1) fd_seen++;
        if (!reset) begin
            check("reset_done", done, 1);
            check("reset_valid", valid, 0);
            exp_q.delete();
            gap_left = 0;
            fd_due   = 0;
            pend     = 0;
        end else if (pend) begin
            check("trig_idle_done", done, 1);
            check("trig_idle_valid", valid, 0);
            pend = 0;
            if (!abort) build_job();
        end else if (gap_left > 0) begin
            check("gap_valid", valid, 0);
            check("gap_done", done, 0);
            check("gap_frame_done", frame_done, 32'(fd_due));
            fd_due = 0;
            gap_left--;
            if (abort) begin
                exp_q.delete();
                gap_left = 0;
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q[0];
            check("send_valid", valid, 1);
            check("send_addr", addr, e.addr);
            check("send_chan", chan, e.chan);
            check("send_last", last, 32'(e.last));
            check("send_frame_done", frame_done, 0);
            if (abort) begin
                exp_q.delete();
            end else if (nxt) begin
                void'(exp_q.pop_front());
                if (e.last) begin
                    gap_left = m_gap + 1;
                    fd_due   = 1;
                end
            end
        end else begin
            check("idle_done", done, 1);
            check("idle_valid", valid, 0);
            check("idle_frame_done", frame_done, 0);
        end
    end

    task automatic start(input logic [7:0] b, input logic [7:0] l, input logic [1:0] c,
                         input logic [7:0] r, input logic [15:0] g, input bit rv);
        @(posedge clk); #1;
        base = b; length = l; chans_m1 = c; repeat_cnt = r; gap = g; reverse = rv;
        m_base = b; m_len = l; m_cm1 = c; m_rep = r; m_gap = int'(g);
`ifdef SEND_SEQ_REVERSE_EN
        m_rev = rv;
`else
        m_rev = 0;
`endif
        trigger = 1'b1;
        pend    = 1;
        @(posedge clk); #1;
        trigger = 1'b0;
        // Scramble inputs: the running frame must use the latched copies.
        base = ~b; length = ~l; chans_m1 = ~c; repeat_cnt = ~r; gap = ~g; reverse = ~rv;
    endtask

    task automatic wait_idle(input int budget, input bit toggle_next);
        int k = 0;
        while (!(done && exp_q.size() == 0 && gap_left == 0 && !pend) && k < budget) begin
            @(posedge clk); #1;
            if (toggle_next) nxt = ~nxt;
            @(negedge clk); #1;
            k++;
        end
        check("idle_within_budget", 32'(k < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int fd_before;

    initial begin
        reset = 1'b0; trigger = 1'b0; abort = 1'b0; nxt = 1'b0; reverse = 1'b0;
        base = '0; length = '0; chans_m1 = '0; repeat_cnt = '0; gap = '0;
        repeat (2) @(negedge clk);
        check("rst_addr", addr, 0);
        check("rst_chan", chan, 0);
        check("rst_last", last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_done_lit", done, 1);
        @(posedge clk); #1 reset = 1'b1;

        // Basic frame: 3 pixels x 3 channels, gap 3.
        nxt = 1'b1;
        start(8'h10, 8'd2, 2'd2, 8'd0, 16'd3, 0);
        @(negedge clk);
        check("basic_first_addr", addr, 8'h10);
        check("basic_first_chan", chan, 0);
        repeat (8) @(negedge clk);
        check("basic_9th_last", last, 1);
        check("basic_9th_addr", addr, 8'h12);
        check("basic_9th_chan", chan, 2);
        @(negedge clk);
        check("basic_frame_done", frame_done, 1);
        repeat (3) @(negedge clk);
        check("basic_gap4_done", done, 0);
        @(negedge clk);
        check("basic_after_gap_done", done, 1);
        wait_idle(50, 0);

        // Wrap and repeat.
        fd_before = fd_seen;
        start(8'hFE, 8'd3, 2'd0, 8'd1, 16'd0, 0);
        @(negedge clk);
        check("wrap_first_addr", addr, 8'hFE);
        repeat (2) @(negedge clk);
        check("wrap_third_addr", addr, 8'h00);
        wait_idle(50, 0);
        #1 check("wrap_two_frame_done", fd_seen - fd_before, 2);

        // Backpressure: next toggles, elements hold while low.
        nxt = 1'b0;
        start(8'h20, 8'd1, 2'd1, 8'd0, 16'd1, 0);
        @(negedge clk);
        check("bp_first_chan", chan, 0);
        @(posedge clk); #1 nxt = 1'b1;
        @(negedge clk);
        check("bp_held_chan", chan, 0);
        wait_idle(60, 1);

        // Abort during the second pixel; a trigger in SEND is ignored first.
        nxt = 1'b1;
        start(8'h30, 8'd3, 2'd1, 8'd0, 16'd2, 0);
        @(posedge clk); #1 trigger = 1'b1;
        @(posedge clk); #1 trigger = 1'b0; abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_send_done", done, 1);
        check("abort_send_addr_held", addr, 8'h31);
        check("abort_send_chan_held", chan, 0);
        check("abort_send_no_fd", frame_done, 0);
        repeat (6) @(negedge clk);

        // Abort in GAP with repeats pending: no further frames.
        fd_before = fd_seen;
        start(8'h40, 8'd0, 2'd0, 8'd2, 16'd5, 0);
        @(negedge clk);
        check("single_elem_last", last, 1);
        @(posedge clk); #1;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (12) @(negedge clk);
        #1 check("abort_gap_one_fd", fd_seen - fd_before, 1);
        check("abort_gap_done", done, 1);

        // Trigger together with abort in IDLE: abort wins.
        @(posedge clk); #1;
        m_base = 8'h60; m_len = 8'd1; m_cm1 = 2'd0; m_rep = 8'd0; m_gap = 0; m_rev = 0;
        base = 8'h60; length = 8'd1;
        trigger = 1'b1; abort = 1'b1; pend = 1;
        @(posedge clk); #1 trigger = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("trig_abort_idle", done, 1);

        // Asynchronous reset mid-GAP, then a clean restart.
        start(8'h50, 8'd1, 2'd0, 8'd0, 16'd20, 0);
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_rst_done", done, 1);
        check("async_rst_valid", valid, 0);
        check("async_rst_addr", addr, 0);
        @(posedge clk); #1 reset = 1'b1;
        start(8'h50, 8'd1, 2'd0, 8'd0, 16'd1, 0);
        @(negedge clk);
        check("restart_addr", addr, 8'h50);
        wait_idle(50, 0);

`ifdef SEND_SEQ_REVERSE_EN
        start(8'h00, 8'd2, 2'd0, 8'd0, 16'd0, 1);
        @(negedge clk);
        check("rev_first_addr", addr, 8'h02);
        repeat (2) @(negedge clk);
        check("rev_last_addr", addr, 8'h00);
        check("rev_last_flag", last, 1);
        wait_idle(50, 0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
